cpu_ctrl_fsm: RTL and testbench

- Multi-cycle fetch/execute controller for the 16-bit CPU core.
- Drives the ALU from the opposite side of its interface:
  - outputs: opcode (alu_op), B-operand select, flag-update enable.
  - inputs: ALU result and the 4-bit FLAGS register.
- Owns the PC and instruction register, sequences instruction/data memory handshakes, controls the external register file, and resolves conditional branches from FLAGS.

---
 rtl/cpu_ctrl_pkg.sv | 57 +++++
 rtl/cpu_ctrl_fsm_branch_cond.sv | 31 +++
 rtl/cpu_ctrl_fsm.sv | 173 +++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU fetch/execute controller: opcodes,
// branch condition codes, FSM state encoding, FLAGS bit positions and
// immediate sign-extension helpers.
package cpu_ctrl_pkg;

  // Register-register ALU opcodes; the low three bits double as alu_op
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  // Control / memory / immediate opcodes
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Branch condition codes carried in the rd field of BR
  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_Z  = 3'b001;
  localparam logic [2:0] CC_NZ = 3'b010;
  localparam logic [2:0] CC_C  = 3'b011;
  localparam logic [2:0] CC_NC = 3'b100;
  localparam logic [2:0] CC_S  = 3'b101;
  localparam logic [2:0] CC_NS = 3'b110;
  localparam logic [2:0] CC_NV = 3'b111;

  // FLAGS register bit positions
  localparam int FL_VALID = 0;
  localparam int FL_Z     = 1;
  localparam int FL_C     = 2;
  localparam int FL_S     = 3;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_branch_cond.sv
// Combinational branch resolver: decides whether a BR is taken from its
// condition code and the ALU FLAGS. Any flag-dependent condition is only
// taken when the FLAGS register holds a valid result.
module branch_cond
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic valid;
  assign valid = flags[FL_VALID];

  // Condition-code decode
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL:   taken = 1'b1;
      CC_Z:    taken = valid &  flags[FL_Z];
      CC_NZ:   taken = valid & ~flags[FL_Z];
      CC_C:    taken = valid &  flags[FL_C];
      CC_NC:   taken = valid & ~flags[FL_C];
      CC_S:    taken = valid &  flags[FL_S];
      CC_NS:   taken = valid & ~flags[FL_S];
      CC_NV:   taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/execute controller for the 16-bit core. Owns PC and IR,
// sequences instruction and data memory handshakes, drives the register
// file write port and the ALU control side, and resolves BR from FLAGS.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [2:0]  rf_ra_addr,
  output logic [2:0]  rf_rb_addr,
  input  logic [15:0] rf_ra_data,
  input  logic [15:0] rf_rb_data,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [2:0]  alu_op,
  output logic        alu_bsel,
  output logic [15:0] alu_b_imm,
  output logic        en_flags,
  input  logic [15:0] alu_s,
  input  logic [3:0]  flags,
  output logic        halted
);

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;

  // Instruction fields
  logic [3:0] opcode;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [5:0] imm6;
  logic [8:0] imm9;
  logic       br_taken;

  assign opcode = ir_reg[15:12];
  assign rd     = ir_reg[11:9];
  assign rs     = ir_reg[8:6];
  assign imm6   = ir_reg[5:0];
  assign imm9   = ir_reg[8:0];

  // Address/data pass-throughs stay live in every state
  assign imem_addr  = pc_reg;
  assign dmem_addr  = rf_rb_data;
  assign dmem_wdata = rf_ra_data;
  assign rf_ra_addr = rd;
  assign rf_rb_addr = rs;
  assign rf_waddr   = rd;
  assign alu_b_imm  = sext6(imm6);

  branch_cond u_branch_cond (
    .cond  (rd),
    .flags (flags),
    .taken (br_taken)
  );

  // State, PC and IR registers; reset drops all requests immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_BOOT;
      pc_reg    <= RESET_PC;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  // Next-state, PC/IR update and control outputs
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    rf_wdata   = 16'h0000;
    alu_op     = 3'b000;
    alu_bsel   = 1'b0;
    en_flags   = 1'b0;
    halted     = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_next    = imem_rdata;
          pc_next    = pc_reg + 16'd1;
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_next = ST_FETCH;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
            alu_op   = opcode[2:0];
            rf_we    = 1'b1;
            rf_wdata = alu_s;
            en_flags = 1'b1;
          end
          OP_ADDI: begin
            alu_op   = OP_ADD[2:0];
            alu_bsel = 1'b1;
            rf_we    = 1'b1;
            rf_wdata = alu_s;
            en_flags = 1'b1;
          end
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = {7'b0, imm9};
          end
          OP_LD, OP_ST: begin
            state_next = ST_MEM;
          end
          OP_BR: begin
            // pc_reg already points at the next instruction here
            if (br_taken) pc_next = pc_reg + sext9(imm9);
          end
          OP_JR: begin
            pc_next = rf_rb_data;
          end
          OP_HALT: begin
            state_next = ST_HALT;
          end
          default: begin
            state_next = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_ST);
        if (dmem_ack) begin
          state_next = ST_FETCH;
          if (opcode == OP_LD) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: memories, register file and ALU are
// modelled around the controller; expected fetch/write/data events are
// queued by the stimulus and popped by a negedge monitor.
module tb_cpu_ctrl_fsm;

  localparam logic [15:0] RST_PC = 16'h0010;

  localparam int EV_F = 0;  // instruction fetch accepted
  localparam int EV_W = 1;  // register file write
  localparam int EV_D = 2;  // data access completed

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [2:0]  rf_ra_addr;
  logic [2:0]  rf_rb_addr;
  logic [15:0] rf_ra_data;
  logic [15:0] rf_rb_data;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  alu_op;
  logic        alu_bsel;
  logic [15:0] alu_b_imm;
  logic        en_flags;
  logic [15:0] alu_s;
  logic [3:0]  flags;
  logic        halted;

  cpu_ctrl_fsm #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_ra_data (rf_ra_data),
    .rf_rb_data (rf_rb_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_op     (alu_op),
    .alu_bsel   (alu_bsel),
    .alu_b_imm  (alu_b_imm),
    .en_flags   (en_flags),
    .alu_s      (alu_s),
    .flags      (flags),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [15:0] imem_mem [0:65535];
  logic [15:0] dmem_mem [0:255];
  logic [15:0] regs [0:7];
  logic        imem_stall;
  int          dmem_cnt;
  int          cyc;

  assign imem_ack   = imem_req && !imem_stall;
  assign imem_rdata = imem_mem[imem_addr];
  // address 0x20 answers after 3 wait cycles, everything else zero-wait
  assign dmem_ack   = dmem_req && (dmem_cnt == ((dmem_addr[7:0] == 8'h20) ? 3 : 0));
  assign dmem_rdata = dmem_mem[dmem_addr[7:0]];
  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rb_data = regs[rf_rb_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) dmem_cnt <= 0;
    else if (!dmem_req || dmem_ack) dmem_cnt <= 0;
    else dmem_cnt <= dmem_cnt + 1;
  end

  logic [15:0] alu_b;
  logic [16:0] alu_full;
  always_comb begin
    alu_b    = alu_bsel ? alu_b_imm : rf_rb_data;
    alu_full = 17'd0;
    case (alu_op)
      3'd0: alu_full = {1'b0, rf_ra_data} + {1'b0, alu_b};
      3'd1: alu_full = {1'b0, rf_ra_data} - {1'b0, alu_b};
      3'd2: alu_full = {1'b0, rf_ra_data & alu_b};
      3'd3: alu_full = {1'b0, rf_ra_data | alu_b};
      3'd4: alu_full = {1'b0, rf_ra_data ^ alu_b};
      3'd5: alu_full = {1'b0, ~rf_ra_data};
      3'd6: alu_full = {rf_ra_data, 1'b0};
      default: alu_full = {1'b0, rf_ra_data >> 1};
    endcase
    alu_s = alu_full[15:0];
  end

  // ALU flag register latches at the negedge inside EXEC
  always @(negedge clk or posedge rst) begin
    if (rst) flags <= 4'h0;
    else if (en_flags) flags <= {alu_s[15], alu_full[16], (alu_s == 16'h0), 1'b1};
  end

  // ---------------- checking infrastructure ----------------
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    bit          flag;
    logic [2:0]  op;
    int          len;
    bit          chk_data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  sb_active = 0;
  int  dmem_run = 0;
  int  fcyc[int];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic push_f(input logic [15:0] a);
    ev_t e;
    e.kind = EV_F; e.addr = a; e.data = 0; e.flag = 0; e.op = 0; e.len = 0; e.chk_data = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_w(input logic [2:0] r, input logic [15:0] d, input bit fl, input logic [2:0] op);
    ev_t e;
    e.kind = EV_W; e.addr = {13'd0, r}; e.data = d; e.flag = fl; e.op = op; e.len = 0; e.chk_data = 1;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input bit we, input logic [15:0] a, input logic [15:0] d, input int len);
    ev_t e;
    e.kind = EV_D; e.addr = a; e.data = d; e.flag = we; e.op = 0; e.len = len; e.chk_data = we;
    exp_q.push_back(e);
  endtask

  task automatic sb_take(input int kind, output ev_t e, output bit ok);
    ok = 0;
    e.kind = -1; e.addr = 0; e.data = 0; e.flag = 0; e.op = 0; e.len = 0; e.chk_data = 0;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_event_kind", kind, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("sb_event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  // Monitor: one line per observed transaction, compared against the queue
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (dmem_req) dmem_run++; else dmem_run = 0;
    if (sb_active && !rst) begin
      if (dmem_req && dmem_ack) begin
        $display("txn DMEM we=%0d addr=%h wdata=%h len=%0d", dmem_we, dmem_addr, dmem_wdata, dmem_run);
        sb_take(EV_D, e, ok);
        if (ok) begin
          chk("dmem_we", dmem_we, e.flag);
          chk("dmem_addr", dmem_addr, e.addr);
          if (e.chk_data) chk("dmem_wdata", dmem_wdata, e.data);
          chk("dmem_req_len", dmem_run, e.len);
        end
        dmem_run = 0;
      end
      if (rf_we) begin
        $display("txn RFW r%0d=%h en_flags=%0d alu_op=%0d", rf_waddr, rf_wdata, en_flags, alu_op);
        sb_take(EV_W, e, ok);
        if (ok) begin
          chk("rf_waddr", rf_waddr, e.addr);
          chk("rf_wdata", rf_wdata, e.data);
          chk("en_flags", en_flags, e.flag);
          if (e.flag) chk("alu_op", alu_op, e.op);
        end
      end
      if (imem_req && imem_ack) begin
        $display("txn FETCH addr=%h data=%h cyc=%0d", imem_addr, imem_rdata, cyc);
        fcyc[int'(imem_addr)] = cyc;
        sb_take(EV_F, e, ok);
        if (ok) chk("fetch_addr", imem_addr, e.addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_imem();
    for (int i = 0; i < 65536; i++) imem_mem[i] = 16'hF000;
  endtask

  task automatic load_prog_a(input logic [8:0] k);
    fill_imem();
    imem_mem[16'h0010] = 16'h9205;           // LDI r1,5
    imem_mem[16'h0011] = 16'h9400 | {7'd0, k}; // LDI r2,k
    imem_mem[16'h0012] = 16'h1280;           // SUB r1,r2
    imem_mem[16'h0013] = 16'h9E00;           // LDI r7,0
    imem_mem[16'h0014] = 16'hD1C0;           // JR r7
    imem_mem[16'h0000] = 16'hE000;           // NOP x4
    imem_mem[16'h0001] = 16'hE000;
    imem_mem[16'h0002] = 16'hE000;
    imem_mem[16'h0003] = 16'hE000;
    imem_mem[16'h0004] = 16'hC203;           // BR Z,+3
    imem_mem[16'h0008] = 16'hCE05;           // BR NV,+5
    imem_mem[16'h0009] = 16'hF000;           // HALT
  endtask

  task automatic push_prog_a(input logic [15:0] k, input logic [15:0] diff);
    push_f(16'h0010); push_w(3'd1, 16'd5, 0, 3'd0);
    push_f(16'h0011); push_w(3'd2, k, 0, 3'd0);
    push_f(16'h0012); push_w(3'd1, diff, 1, 3'd1);
    push_f(16'h0013); push_w(3'd7, 16'h0000, 0, 3'd0);
    push_f(16'h0014);
    push_f(16'h0000); push_f(16'h0001); push_f(16'h0002); push_f(16'h0003);
    push_f(16'h0004);
  endtask

  task automatic release_and_check_boot();
    @(negedge clk);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_halted", halted, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    rst = 1'b0;
    #1;
    chk("boot_no_req", imem_req, 1'b0);
    @(posedge clk); #1;
    chk("fetch_req_after_boot", imem_req, 1'b1);
    chk("fetch_addr_after_boot", imem_addr, RST_PC);
  endtask

  task automatic wait_halt(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      if (halted) done = 1;
    end
    chk("halt_reached", done, 1'b1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int req_cnt;
    bit drained;
    rst = 1'b1;
    imem_stall = 1'b0;
    cyc = 0;
    for (int i = 0; i < 256; i++) dmem_mem[i] = 16'h0000;
    dmem_mem[8'h20] = 16'hBEEF;

    // Zero result: BR Z taken to 0x0008, BR NV falls through, HALT
    load_prog_a(9'd5);
    repeat (3) @(posedge clk);
    push_prog_a(16'd5, 16'd0);
    push_f(16'h0008); push_f(16'h0009);
    sb_active = 1'b1;
    release_and_check_boot();
    wait_halt(200);
    chk("sub_to_fetch_cycles", fcyc[16'h0013] - fcyc[16'h0010], 6);
    req_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req) req_cnt++;
    end
    chk("halt_no_requests", req_cnt, 0);
    chk("halt_held", halted, 1'b1);

    // Reset out of HALT; nonzero result: BR Z not taken, next fetch 0x0005
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_clears_halted", halted, 1'b0);
    load_prog_a(9'd4);
    push_prog_a(16'd4, 16'd1);
    push_f(16'h0005);
    release_and_check_boot();
    wait_halt(200);

    // Memory ops, JR to FFFF, PC wrap, BR -1 self-loop at 0x0000
    @(negedge clk);
    rst = 1'b1;
    fill_imem();
    imem_mem[16'h0010] = 16'h9420;  // LDI r2,0x20
    imem_mem[16'h0011] = 16'hA680;  // LD  r3,[r2]
    imem_mem[16'h0012] = 16'h9421;  // LDI r2,0x21
    imem_mem[16'h0013] = 16'hB680;  // ST  r3,[r2]
    imem_mem[16'h0014] = 16'h9800;  // LDI r4,0
    imem_mem[16'h0015] = 16'h9A01;  // LDI r5,1
    imem_mem[16'h0016] = 16'h1940;  // SUB r4,r5
    imem_mem[16'h0017] = 16'hD100;  // JR  r4
    imem_mem[16'hFFFF] = 16'hE000;  // NOP
    imem_mem[16'h0000] = 16'hC1FF;  // BR AL,-1
    push_f(16'h0010); push_w(3'd2, 16'h0020, 0, 3'd0);
    push_f(16'h0011); push_d(1'b0, 16'h0020, 16'h0000, 4); push_w(3'd3, 16'hBEEF, 0, 3'd0);
    push_f(16'h0012); push_w(3'd2, 16'h0021, 0, 3'd0);
    push_f(16'h0013); push_d(1'b1, 16'h0021, 16'hBEEF, 1);
    push_f(16'h0014); push_w(3'd4, 16'h0000, 0, 3'd0);
    push_f(16'h0015); push_w(3'd5, 16'h0001, 0, 3'd0);
    push_f(16'h0016); push_w(3'd4, 16'hFFFF, 1, 3'd1);
    push_f(16'h0017);
    push_f(16'hFFFF);
    push_f(16'h0000); push_f(16'h0000); push_f(16'h0000);
    release_and_check_boot();
    drained = 0;
    for (int i = 0; i < 300 && !drained; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) drained = 1;
    end
    sb_active = 1'b0;
    chk("mem_prog_drained", drained, 1'b1);
    chk("loop_not_halted", halted, 1'b0);

    // Reset asserted mid-fetch drops imem_req without a clock edge
    @(negedge clk);
    rst = 1'b1;
    imem_stall = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    chk("stalled_fetch_req", imem_req, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_drops_req", imem_req, 1'b0);
    chk("async_rst_pc", imem_addr, RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
